// File: rtl/gsensor_scheduler.sv
// ADXL345 transaction sequencer: writes the configuration table after reset, then reads
// the six axis bytes on data-ready (or poll expiry) and publishes zero-compensated X/Y/Z.
module gsensor_scheduler #(
    parameter int         POLL_CYCLES    = 500000,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [7:0] BW_RATE_VAL    = 8'h09,
    parameter logic [7:0] FORMAT_VAL     = 8'h40
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iG_INT2,
    input  logic        iZERO,
    output logic        oTX_REQ,
    output logic        oTX_RW,
    output logic [5:0]  oTX_ADDR,
    output logic [7:0]  oTX_WDATA,
    input  logic        iTX_ACK,
    input  logic        iTX_DONE,
    input  logic [7:0]  iTX_RDATA,
    output logic [15:0] oX,
    output logic [15:0] oY,
    output logic [15:0] oZ,
    output logic        oVALID,
    output logic        oINIT_DONE,
    output logic        oERR
);
    localparam int            PW        = $clog2(POLL_CYCLES + 1);
    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_INIT_REQ,
        S_INIT_WAIT,
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_COMMIT
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [2:0]         r_idx, w_idx_nxt;
    logic               r_int2_meta, r_int2_sync;
    logic [PW-1:0]      r_poll;
    logic [TW-1:0]      r_wd;
    logic [5:0][7:0]    r_raw;
    logic signed [15:0] r_craw_x, r_craw_y, r_craw_z;
    logic signed [15:0] r_zero_x, r_zero_y, r_zero_z;
    logic signed [15:0] r_out_x, r_out_y, r_out_z;
    logic               r_tx_req, r_tx_rw;
    logic [5:0]         r_tx_addr;
    logic [7:0]         r_tx_wdata;
    logic               r_valid, r_init_done, r_err;
    logic               w_ack_ok, w_poll_hit, w_wd_hit, w_err, w_init_fin;
    logic signed [15:0] w_new_x, w_new_y, w_new_z;

    function automatic logic [5:0] init_addr(input logic [2:0] idx);
        case (idx)
            3'd0:    init_addr = 6'h31;
            3'd1:    init_addr = 6'h2C;
            3'd2:    init_addr = 6'h2F;
            3'd3:    init_addr = 6'h2E;
            default: init_addr = 6'h2D;
        endcase
    endfunction

    function automatic logic [7:0] init_data(input logic [2:0] idx);
        case (idx)
            3'd0:    init_data = FORMAT_VAL;
            3'd1:    init_data = BW_RATE_VAL;
            3'd2:    init_data = 8'h80;
            3'd3:    init_data = 8'h80;
            default: init_data = 8'h08;
        endcase
    endfunction

    // Two's complement difference, deliberately wrapping modulo 2^16 (no saturation).
    function automatic logic signed [15:0] sub_wrap(input logic signed [15:0] a,
                                                    input logic signed [15:0] b);
        sub_wrap = a - b;
    endfunction

    assign w_ack_ok   = iTX_ACK & r_tx_req;
    assign w_poll_hit = (r_poll == POLL_LAST);
    assign w_wd_hit   = (r_wd == TMO_LAST);
    assign w_new_x    = {r_raw[1], r_raw[0]};
    assign w_new_y    = {r_raw[3], r_raw[2]};
    assign w_new_z    = {r_raw[5], r_raw[4]};

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_err       = 1'b0;
        w_init_fin  = 1'b0;
        case (r_state)
            S_INIT_REQ: if (w_ack_ok) w_state_nxt = S_INIT_WAIT;
            S_INIT_WAIT: begin
                if (iTX_DONE) begin
                    if (r_idx == 3'd4) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = 3'd0;
                        w_init_fin  = 1'b1;
                    end else begin
                        w_state_nxt = S_INIT_REQ;
                        w_idx_nxt   = r_idx + 3'd1;
                    end
                end else if (w_wd_hit) begin
                    w_state_nxt = S_INIT_REQ;
                    w_idx_nxt   = 3'd0;
                    w_err       = 1'b1;
                end
            end
            S_IDLE: begin
                if (r_int2_sync || w_poll_hit) begin
                    w_state_nxt = S_RD_REQ;
                    w_idx_nxt   = 3'd0;
                end
            end
            S_RD_REQ: if (w_ack_ok) w_state_nxt = S_RD_WAIT;
            S_RD_WAIT: begin
                if (iTX_DONE) begin
                    if (r_idx == 3'd5) begin
                        w_state_nxt = S_COMMIT;
                        w_idx_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = S_RD_REQ;
                        w_idx_nxt   = r_idx + 3'd1;
                    end
                end else if (w_wd_hit) begin
                    w_state_nxt = S_INIT_REQ;
                    w_idx_nxt   = 3'd0;
                    w_err       = 1'b1;
                end
            end
            S_COMMIT: w_state_nxt = S_IDLE;
            default: begin
                w_state_nxt = S_INIT_REQ;
                w_idx_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= S_INIT_REQ;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Poll timer runs only while idling; watchdog only while a transaction is in flight.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_int2_meta <= 1'b0;
            r_int2_sync <= 1'b0;
            r_poll      <= '0;
            r_wd        <= '0;
        end else begin
            r_int2_meta <= iG_INT2;
            r_int2_sync <= r_int2_meta;
            r_poll      <= (r_state == S_IDLE && w_state_nxt == S_IDLE) ? r_poll + 1'b1 : '0;
            r_wd        <= ((r_state == S_INIT_WAIT || r_state == S_RD_WAIT) &&
                            w_state_nxt == r_state) ? r_wd + 1'b1 : '0;
        end
    end

    // Request fields are registered from the next state so they are stable for the whole request.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_tx_req    <= 1'b0;
            r_tx_rw     <= 1'b0;
            r_tx_addr   <= '0;
            r_tx_wdata  <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_tx_req <= (w_state_nxt == S_INIT_REQ) || (w_state_nxt == S_RD_REQ);
            r_tx_rw  <= (w_state_nxt == S_RD_REQ);
            case (w_state_nxt)
                S_INIT_REQ: begin
                    r_tx_addr  <= init_addr(w_idx_nxt);
                    r_tx_wdata <= init_data(w_idx_nxt);
                end
                S_RD_REQ: begin
                    r_tx_addr  <= 6'h32 + {3'b000, w_idx_nxt};
                    r_tx_wdata <= 8'h00;
                end
                default: begin
                    r_tx_addr  <= '0;
                    r_tx_wdata <= '0;
                end
            endcase
            r_valid <= (r_state == S_COMMIT);
            r_err   <= w_err;
            if (w_err)
                r_init_done <= 1'b0;
            else if (w_init_fin)
                r_init_done <= 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_raw    <= '0;
            r_craw_x <= '0;
            r_craw_y <= '0;
            r_craw_z <= '0;
            r_zero_x <= '0;
            r_zero_y <= '0;
            r_zero_z <= '0;
            r_out_x  <= '0;
            r_out_y  <= '0;
            r_out_z  <= '0;
        end else begin
            if (r_state == S_RD_WAIT && iTX_DONE)
                r_raw[r_idx] <= iTX_RDATA;
            if (r_state == S_COMMIT) begin
                r_craw_x <= w_new_x;
                r_craw_y <= w_new_y;
                r_craw_z <= w_new_z;
                if (iZERO) begin
                    r_zero_x <= w_new_x;
                    r_zero_y <= w_new_y;
                    r_zero_z <= w_new_z;
                    r_out_x  <= '0;
                    r_out_y  <= '0;
                    r_out_z  <= '0;
                end else begin
                    r_out_x <= sub_wrap(w_new_x, r_zero_x);
                    r_out_y <= sub_wrap(w_new_y, r_zero_y);
                    r_out_z <= sub_wrap(w_new_z, r_zero_z);
                end
            end else if (iZERO) begin
                // Zero becomes the committed sample, so the recomputed outputs are all zero.
                r_zero_x <= r_craw_x;
                r_zero_y <= r_craw_y;
                r_zero_z <= r_craw_z;
                r_out_x  <= '0;
                r_out_y  <= '0;
                r_out_z  <= '0;
            end
        end
    end

    assign oTX_REQ    = r_tx_req;
    assign oTX_RW     = r_tx_rw;
    assign oTX_ADDR   = r_tx_addr;
    assign oTX_WDATA  = r_tx_wdata;
    assign oX         = r_out_x;
    assign oY         = r_out_y;
    assign oZ         = r_out_z;
    assign oVALID     = r_valid;
    assign oINIT_DONE = r_init_done;
    assign oERR       = r_err;
endmodule
